// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART_RX config owner with idle-guarded reconfiguration and FWFT byte FIFO (option: UART_RX_CTRL_FLUSH_ON_CFG_EN)
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_BITS  = 2,
  parameter int CNT_W      = 8
) (
  input  logic                          clk_based_on_prescale,
  input  logic                          asy_reset,
  input  logic                          RX_IN,
  input  logic                          cfg_req,
  input  logic [5:0]                    cfg_prescale,
  input  logic                          cfg_par_en,
  input  logic                          cfg_par_type,
  output logic                          cfg_ack,
  output logic                          cfg_err,
  output logic [5:0]                    prescale,
  output logic                          parity_enable,
  output logic                          parity_type,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              overflow_cnt,
  output logic                          line_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // wide enough for IDLE_BITS * largest 6-bit prescale
  localparam int QW = $clog2(IDLE_BITS * 63 + 1);

  typedef enum logic [2:0] {C_IDLE, C_WAIT, C_APPLY, C_ACK, C_DONE} cfg_state_t;

  cfg_state_t     state, state_nxt;
  logic           latch_en, apply_en, req_ok;
  logic [5:0]     lat_prescale;
  logic           lat_par_en, lat_par_type, err_q;
  logic [QW-1:0]  quiet, qt;
  logic           rx_valid_q, push_req, do_push, pop, full, drop, flush;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [7:0]     mem [FIFO_DEPTH];

  assign req_ok    = (cfg_prescale == 6'd8) || (cfg_prescale == 6'd16) || (cfg_prescale == 6'd32);
  assign qt        = QW'(IDLE_BITS) * QW'(prescale);
  assign line_busy = (quiet < qt);
  assign cfg_err   = cfg_ack & err_q;

  // Idle-line counter: counts consecutive RX_IN=1 cycles, saturating at the current threshold
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset)       quiet <= '0;
    else if (!RX_IN)      quiet <= '0;
    else if (quiet < qt)  quiet <= quiet + QW'(1);
    else                  quiet <= qt;
  end

  // Config FSM state register
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) state <= C_IDLE;
    else            state <= state_nxt;
  end

  // Config FSM next state and strobes
  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    apply_en  = 1'b0;
    cfg_ack   = 1'b0;
    case (state)
      C_IDLE:  if (cfg_req) begin
                 latch_en  = 1'b1;
                 state_nxt = req_ok ? C_WAIT : C_ACK;
               end
      C_WAIT:  if (!line_busy) state_nxt = C_APPLY;
      C_APPLY: begin
                 apply_en  = 1'b1;
                 state_nxt = C_ACK;
               end
      C_ACK:   begin
                 cfg_ack   = 1'b1;
                 state_nxt = C_DONE;
               end
      C_DONE:  if (!cfg_req) state_nxt = C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
  end

  // Request latch and active configuration driving UART_RX
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      lat_prescale  <= 6'd8;
      lat_par_en    <= 1'b0;
      lat_par_type  <= 1'b0;
      err_q         <= 1'b0;
      prescale      <= 6'd8;
      parity_enable <= 1'b0;
      parity_type   <= 1'b0;
    end else begin
      if (latch_en) begin
        lat_prescale <= cfg_prescale;
        lat_par_en   <= cfg_par_en;
        lat_par_type <= cfg_par_type;
        err_q        <= ~req_ok;
      end
      if (apply_en) begin
        prescale      <= lat_prescale;
        parity_enable <= lat_par_en;
        parity_type   <= lat_par_type;
        err_q         <= 1'b0;
      end
    end
  end

`ifdef UART_RX_CTRL_FLUSH_ON_CFG_EN
  assign flush = apply_en;
`else
  assign flush = 1'b0;
`endif

  assign push_req  = rx_valid & ~rx_valid_q;
  assign out_valid = (fifo_count != '0);
  assign out_data  = mem[rd_ptr];
  assign full      = (fifo_count == CW'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready & ~flush;
  assign do_push   = push_req & (~full | pop) & ~flush;
  assign drop      = push_req & full & ~pop & ~flush;

  // rx_valid edge detector so a stretched strobe captures one byte
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) rx_valid_q <= 1'b0;
    else            rx_valid_q <= rx_valid;
  end

  // FIFO storage; contents are don't-care until counted valid
  always_ff @(posedge clk_based_on_prescale) begin
    if (do_push) mem[wr_ptr] <= rx_data;
  end

  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      overflow_cnt <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop && (overflow_cnt != {CNT_W{1'b1}})) overflow_cnt <= overflow_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       asy_reset;
  logic       RX_IN;
  logic       cfg_req;
  logic [5:0] cfg_prescale;
  logic       cfg_par_en, cfg_par_type;
  logic       cfg_ack, cfg_err;
  logic [5:0] prescale;
  logic       parity_enable, parity_type;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fifo_count;
  logic [7:0] overflow_cnt;
  logic       line_busy;

  int checks = 0;
  int failures = 0;

  uart_rx_ctrl #(.FIFO_DEPTH(4), .IDLE_BITS(2), .CNT_W(8)) dut (
    .clk_based_on_prescale(clk),
    .asy_reset(asy_reset),
    .RX_IN(RX_IN),
    .cfg_req(cfg_req),
    .cfg_prescale(cfg_prescale),
    .cfg_par_en(cfg_par_en),
    .cfg_par_type(cfg_par_type),
    .cfg_ack(cfg_ack),
    .cfg_err(cfg_err),
    .prescale(prescale),
    .parity_enable(parity_enable),
    .parity_type(parity_type),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fifo_count(fifo_count),
    .overflow_cnt(overflow_cnt),
    .line_busy(line_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    asy_reset = 1'b0; RX_IN = 1'b1; cfg_req = 1'b0; cfg_prescale = 6'd8;
    cfg_par_en = 1'b0; cfg_par_type = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (prescale !== 6'd8) begin failures++; $display("FAIL rst_prescale got=%0d exp=8", prescale); end
    checks++; if (parity_enable !== 1'b0 || parity_type !== 1'b0) begin failures++; $display("FAIL rst_parity got=%b%b exp=00", parity_enable, parity_type); end
    checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL rst_fifo got=%b/%0d exp=0/0", out_valid, fifo_count); end
    checks++; if (overflow_cnt !== 8'd0) begin failures++; $display("FAIL rst_ovf got=%0d exp=0", overflow_cnt); end
    checks++; if (cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b%b exp=00", cfg_ack, cfg_err); end
    asy_reset = 1'b1;
    repeat (15) @(negedge clk);
    checks++; if (line_busy !== 1'b1) begin failures++; $display("FAIL busy_15 got=%b exp=1", line_busy); end
    @(negedge clk);
    checks++; if (line_busy !== 1'b0) begin failures++; $display("FAIL busy_16 got=%b exp=0", line_busy); end
  endtask

  task automatic test_single_byte;
    rx_data = 8'hA5; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin failures++; $display("FAIL single_head got=%b/%h exp=1/a5", out_valid, out_data); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", fifo_count); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL single_pop got=%0d/%b exp=0/0", fifo_count, out_valid); end
  endtask

  task automatic test_held_valid;
    rx_data = 8'h3C; rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    checks++; if (fifo_count !== 3'd1 || out_data !== 8'h3C) begin failures++; $display("FAIL held_cnt got=%0d/%h exp=1/3c", fifo_count, out_data); end
    @(negedge clk);
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL held_fall got=%0d exp=1", fifo_count); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_overflow;
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'h06;
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_cnt got=%0d exp=4", fifo_count); end
    checks++; if (overflow_cnt !== 8'd1) begin failures++; $display("FAIL ovf_drop got=%0d exp=1", overflow_cnt); end
    // push and pop together while full
    rx_data = 8'h06; rx_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++; if (fifo_count !== 3'd4 || overflow_cnt !== 8'd1) begin failures++; $display("FAIL full_pushpop got=%0d/%0d exp=4/1", fifo_count, overflow_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin failures++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, out_valid, out_data, exp_q[i]); end
      @(negedge clk);
    end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL drain_empty got=%0d exp=0", fifo_count); end
    @(negedge clk);
    checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL ready_empty got=%0d/%b exp=0/0", fifo_count, out_valid); end
    // push and pop together while empty
    rx_data = 8'h77; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++; if (fifo_count !== 3'd1 || out_data !== 8'h77) begin failures++; $display("FAIL empty_pushpop got=%0d/%h exp=1/77", fifo_count, out_data); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL empty_pushpop_pop got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_cfg_reject;
    push_byte(8'h11);
    cfg_prescale = 6'd12; cfg_par_en = 1'b1; cfg_par_type = 1'b1; cfg_req = 1'b1;
    @(negedge clk);
    checks++; if (cfg_ack !== 1'b1 || cfg_err !== 1'b1) begin failures++; $display("FAIL rej_ack got=%b%b exp=11", cfg_ack, cfg_err); end
    checks++; if (prescale !== 6'd8 || parity_enable !== 1'b0) begin failures++; $display("FAIL rej_cfg got=%0d/%b exp=8/0", prescale, parity_enable); end
    @(negedge clk);
    checks++; if (cfg_ack !== 1'b0) begin failures++; $display("FAIL rej_pulse got=%b exp=0", cfg_ack); end
    cfg_req = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== 3'd1 || out_data !== 8'h11) begin failures++; $display("FAIL rej_fifo got=%0d/%h exp=1/11", fifo_count, out_data); end
  endtask

  task automatic test_cfg_apply;
    int ack_seen;
    logic [2:0] exp_cnt;
`ifdef UART_RX_CTRL_FLUSH_ON_CFG_EN
    exp_cnt = 3'd0;
`else
    exp_cnt = 3'd1;
`endif
    ack_seen = 0;
    RX_IN = 1'b0; cfg_prescale = 6'd16; cfg_par_en = 1'b1; cfg_par_type = 1'b1; cfg_req = 1'b1;
    @(negedge clk);
    cfg_prescale = 6'd32; cfg_par_en = 1'b0; cfg_par_type = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cfg_ack) ack_seen++;
      @(negedge clk);
    end
    checks++; if (ack_seen !== 0 || prescale !== 6'd8) begin failures++; $display("FAIL busy_hold got=%0d/%0d exp=0/8", ack_seen, prescale); end
    RX_IN = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (cfg_ack) ack_seen++;
    end
    checks++; if (ack_seen !== 0 || prescale !== 6'd8) begin failures++; $display("FAIL pre_apply got=%0d/%0d exp=0/8", ack_seen, prescale); end
    @(negedge clk);
    checks++; if (prescale !== 6'd16 || parity_enable !== 1'b1 || parity_type !== 1'b1) begin failures++; $display("FAIL apply_cfg got=%0d/%b/%b exp=16/1/1", prescale, parity_enable, parity_type); end
    checks++; if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) begin failures++; $display("FAIL apply_ack got=%b%b exp=10", cfg_ack, cfg_err); end
    checks++; if (line_busy !== 1'b1) begin failures++; $display("FAIL apply_busy got=%b exp=1", line_busy); end
    ack_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (cfg_ack) ack_seen++;
    end
    checks++; if (ack_seen !== 0) begin failures++; $display("FAIL ack_once got=%0d exp=0", ack_seen); end
    cfg_req = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== exp_cnt) begin failures++; $display("FAIL apply_fifo got=%0d exp=%0d", fifo_count, exp_cnt); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_req;
    int ack_seen;
    ack_seen = 0;
    RX_IN = 1'b0; cfg_prescale = 6'd32; cfg_req = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    asy_reset = 1'b0;
    cfg_req = 1'b0;
    @(negedge clk);
    checks++; if (prescale !== 6'd8 || parity_enable !== 1'b0 || parity_type !== 1'b0) begin failures++; $display("FAIL mid_rst_cfg got=%0d/%b/%b exp=8/0/0", prescale, parity_enable, parity_type); end
    checks++; if (overflow_cnt !== 8'd0 || fifo_count !== 3'd0 || line_busy !== 1'b1) begin failures++; $display("FAIL mid_rst_state got=%0d/%0d/%b exp=0/0/1", overflow_cnt, fifo_count, line_busy); end
    asy_reset = 1'b1; RX_IN = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (cfg_ack) ack_seen++;
    end
    checks++; if (ack_seen !== 0 || prescale !== 6'd8) begin failures++; $display("FAIL mid_rst_discard got=%0d/%0d exp=0/8", ack_seen, prescale); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 4; i++) push_byte(8'(8'hF0 + i));
    for (int i = 0; i < 256; i++) push_byte(8'(i));
    checks++; if (overflow_cnt !== 8'd255) begin failures++; $display("FAIL sat_ovf got=%0d exp=255", overflow_cnt); end
    checks++; if (fifo_count !== 3'd4 || out_data !== 8'hF0) begin failures++; $display("FAIL sat_fifo got=%0d/%h exp=4/f0", fifo_count, out_data); end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_held_valid;
    test_overflow;
    test_cfg_reject;
    test_cfg_apply;
    test_reset_mid_req;
    test_saturation;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
